dispatch_queue: RTL and testbench
=================================

DISPATCH_QUEUE -- requirements
Module: dispatch_queue

Interface
- REQ-001: Parameter DEPTH, default 8, is the number of queue entries; it SHALL be a power of two and at least 2.
- REQ-002: Parameter DW, default 128, is the width in bits of the control word.
- REQ-003: Parameter NUM_RS, default 4, is the number of ALU reservation stations; it SHALL be at least 1.
- REQ-004: Parameter AFULL, default DEPTH-2, is the almost-full threshold in entries.
- REQ-005: clk_i  in  1  the single clock; all state updates on its rising edge.
- REQ-006: reset_n_i  in  1  reset; one clock, reset asynchronous and active-low.
- REQ-007: flush_i  in  1  synchronous flush after branch mispredict.
- REQ-008: enq_valid_i  in  1  the decoder offers a word.
- REQ-009: enq_data_i  in  DW  the control word.
- REQ-010: enq_class_i  in  2  0=ALU, 1=BRANCH, 2=LOAD, 3=STORE.
- REQ-011: enq_ready_o  out  1  the queue accepts a word this cycle.
- REQ-012: rs_empty_i  in  NUM_RS  per-station free flags.
- REQ-013: br_empty_i / lsq_empty_i  in  1 each  branch-unit / LSQ free flags.
- REQ-014: rob_full_i  in  1  the ROB has no free slot.
- REQ-015: deq_valid_o  out  1  head entry valid; deq_data_o  out  DW  head word.
- REQ-016: rs_load_o  out  NUM_RS  one-hot ALU station load.
- REQ-017: br_load_o, lsq_load_o, rob_load_o, regfile_allocate_o  out  1 each  dispatch strobes.
- REQ-018: count_o  out  $clog2(DEPTH+1)  occupancy; afull_o  out  1  count_o >= AFULL.

Function
- REQ-019: Storage SHALL be a circular buffer of DEPTH entries, each holding {class, data}, with head pointer, tail pointer and count registers.
- REQ-020: enq_ready_o SHALL equal (count < DEPTH) & ~flush_i, with no full-bypass and no combinational path from dispatch inputs.
- REQ-021: An enqueue occurs when enq_valid_i & enq_ready_o; the entry SHALL be written at tail, and tail SHALL advance modulo DEPTH.
- REQ-022: Enqueue-to-head latency SHALL be 1 cycle minimum; there is no same-cycle bypass.
- REQ-023: deq_valid_o SHALL equal (count != 0).
- REQ-024: deq_data_o SHALL be the head data, or all zeros when the queue is empty.
- REQ-025: A dispatch occurs when deq_valid_o & ~rob_full_i & ~flush_i & (target free).
- REQ-026: The target is free as follows: for ALU, |rs_empty_i; for BRANCH, br_empty_i; for LOAD and STORE, lsq_empty_i.
- REQ-027: On an ALU dispatch, rs_load_o SHALL be one-hot at the lowest-index set bit of rs_empty_i; otherwise it SHALL be 0.
- REQ-028: On dispatch, br_load_o SHALL be set for BRANCH and lsq_load_o for LOAD or STORE.
- REQ-029: On dispatch, rob_load_o SHALL be set, and head SHALL advance modulo DEPTH.
- REQ-030: regfile_allocate_o SHALL equal dispatch & (class == ALU or LOAD); STORE and BRANCH SHALL NOT allocate.
- REQ-031: With no dispatch, all load/strobe outputs SHALL be 0 and head SHALL hold; the queue is strictly in-order, with no bypass around a blocked head.
- REQ-032: On simultaneous enqueue and dispatch, count SHALL be unchanged, and both pointers SHALL advance.
- REQ-033: Pointers SHALL wrap from DEPTH-1 to 0 without any loss of entries.
- REQ-034: On flush_i=1, enqueue and dispatch SHALL be suppressed that cycle, and head, tail and count SHALL be 0 on the next edge.
- REQ-035: A flush has priority over all simultaneous events.
- REQ-036: count_o SHALL be the registered count, and afull_o SHALL be derived combinationally from it.
- REQ-037: The block SHALL be 120-400 lines of RTL with no latches, and there is a single clock domain.

Reset
- REQ-038: On reset_n_i=0, head, tail and count SHALL clear to 0 immediately, without waiting for a clock edge.
- REQ-039: Under reset, deq_valid_o, all load outputs, rob_load_o, regfile_allocate_o, count_o and afull_o SHALL be 0, and enq_ready_o SHALL be 1.
- REQ-040: Reset asserted mid-operation SHALL discard all entries, and no dispatch strobe SHALL be issued during reset.
- REQ-041: Entry storage SHALL need no reset, because deq_data_o is zero-masked while empty.

Verification
- REQ-042: Fill without dispatch: 8 enqueues with DEPTH=8 -> count_o=8, afull_o=1 from count 6, enq_ready_o=0, and a 9th word is not accepted.
- REQ-043: Dispatch routing: ALU head, rs_empty_i=4'b1010 -> rs_load_o=4'b0010, rob_load_o=1, regfile_allocate_o=1.
- REQ-044: ROB backpressure: STORE head, lsq_empty_i=1, rob_full_i=1 -> no strobes and head held; after rob_full_i drops -> lsq_load_o=1 and regfile_allocate_o=0.
- REQ-045: Wrap-around: 20 words streamed with simultaneous enqueue and dispatch -> dispatched in order, count_o stays constant, and data matches.
- REQ-046: Flush: flush_i with count_o=5 and enq_valid_i=1 -> no strobes that cycle, count_o=0 next cycle, and the offered word is dropped.
- REQ-047: Async reset: reset_n_i asserted mid-cycle with count 3 -> count_o=0 and deq_valid_o=0 before the next clock edge.

Source files
------------

// File: rtl/dispatch_queue_if.sv
// Purpose: decoder-to-dispatch-queue enqueue handshake bundle.
// Signals (suffix direction is as seen by the queue):
//   enq_valid_i  decoder offers a word
//   enq_data_i   DW-bit control word
//   enq_class_i  0=ALU, 1=BRANCH, 2=LOAD, 3=STORE
//   enq_ready_o  queue accepts the word this cycle
// Modports: master = decoder side, slave = queue side.
interface dispatch_queue_if #(
  parameter int unsigned DW = 128
);
  logic          enq_valid_i;
  logic [DW-1:0] enq_data_i;
  logic [1:0]    enq_class_i;
  logic          enq_ready_o;

  modport master (
    output enq_valid_i,
    output enq_data_i,
    output enq_class_i,
    input  enq_ready_o
  );

  modport slave (
    input  enq_valid_i,
    input  enq_data_i,
    input  enq_class_i,
    output enq_ready_o
  );
endinterface

// File: rtl/dispatch_queue.sv
// Purpose: in-order dispatch queue between decode and the execution units.
//   Circular buffer of {class, data}; the head entry is routed to an ALU
//   reservation station, the branch unit or the LSQ when the target and the
//   ROB both have room. A flush empties the queue on the next edge.
// Ports:
//   clk_i, reset_n_i        clock, async active-low reset
//   flush_i                 synchronous flush (mispredict)
//   enq_if (slave)          enqueue handshake from the decoder
//   rs_empty_i / br_empty_i / lsq_empty_i / rob_full_i   target status
//   deq_valid_o, deq_data_o head entry
//   rs_load_o, br_load_o, lsq_load_o, rob_load_o, regfile_allocate_o  strobes
//   count_o, afull_o        occupancy and almost-full
module dispatch_queue #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DW     = 128,
  parameter int unsigned NUM_RS = 4,
  parameter int unsigned AFULL  = DEPTH - 2
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       flush_i,
  dispatch_queue_if.slave            enq_if,
  input  logic [NUM_RS-1:0]          rs_empty_i,
  input  logic                       br_empty_i,
  input  logic                       lsq_empty_i,
  input  logic                       rob_full_i,
  output logic                       deq_valid_o,
  output logic [DW-1:0]              deq_data_o,
  output logic [NUM_RS-1:0]          rs_load_o,
  output logic                       br_load_o,
  output logic                       lsq_load_o,
  output logic                       rob_load_o,
  output logic                       regfile_allocate_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       afull_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  localparam logic [1:0] CLS_ALU    = 2'd0;
  localparam logic [1:0] CLS_BRANCH = 2'd1;
  localparam logic [1:0] CLS_LOAD   = 2'd2;
  localparam logic [1:0] CLS_STORE  = 2'd3;

  logic [DW-1:0] r_data  [DEPTH];
  logic [1:0]    r_class [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic              w_enq;
  logic              w_valid;
  logic [1:0]        w_head_class;
  logic              w_target_free;
  logic              w_dispatch;
  logic [NUM_RS-1:0] w_rs_lowest;

  // Enqueue acceptance depends only on registered count and flush.
  assign enq_if.enq_ready_o = (r_count < CW'(DEPTH)) & ~flush_i;
  assign w_enq              = enq_if.enq_valid_i & enq_if.enq_ready_o;

  assign w_valid      = (r_count != '0);
  assign w_head_class = r_class[r_head];

  // Storage carries no reset; empty-queue output is masked instead.
  assign deq_valid_o = w_valid;
  assign deq_data_o  = w_valid ? r_data[r_head] : '0;

  // Target availability for the head entry's class.
  always_comb begin
    w_target_free = 1'b0;
    case (w_head_class)
      CLS_ALU:    w_target_free = |rs_empty_i;
      CLS_BRANCH: w_target_free = br_empty_i;
      CLS_LOAD,
      CLS_STORE:  w_target_free = lsq_empty_i;
      default:    w_target_free = 1'b0;
    endcase
  end

  assign w_dispatch = w_valid & ~rob_full_i & ~flush_i & w_target_free;

  // x & (~x + 1) isolates the lowest set bit.
  assign w_rs_lowest = rs_empty_i & (~rs_empty_i + NUM_RS'(1));

  // Dispatch strobes.
  always_comb begin
    rs_load_o          = '0;
    br_load_o          = 1'b0;
    lsq_load_o         = 1'b0;
    rob_load_o         = 1'b0;
    regfile_allocate_o = 1'b0;
    if (w_dispatch) begin
      rob_load_o = 1'b1;
      case (w_head_class)
        CLS_ALU: begin
          rs_load_o          = w_rs_lowest;
          regfile_allocate_o = 1'b1;
        end
        CLS_BRANCH: br_load_o = 1'b1;
        CLS_LOAD: begin
          lsq_load_o         = 1'b1;
          regfile_allocate_o = 1'b1;
        end
        default: lsq_load_o = 1'b1;
      endcase
    end
  end

  // Entry write at tail.
  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_data[r_tail]  <= enq_if.enq_data_i;
      r_class[r_tail] <= enq_if.enq_class_i;
    end
  end

  // Pointers and count; power-of-two depth makes wrap a natural overflow.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq)      r_tail <= r_tail + AW'(1);
      if (w_dispatch) r_head <= r_head + AW'(1);
      r_count <= r_count + CW'(w_enq) - CW'(w_dispatch);
    end
  end

  assign count_o = r_count;
  assign afull_o = (r_count >= CW'(AFULL));

endmodule

// File: tb/tb_dispatch_queue.sv
// Purpose: directed self-checking bench for dispatch_queue (DEPTH=8, NUM_RS=4).
module tb_dispatch_queue;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned DW     = 128;
  localparam int unsigned NUM_RS = 4;

  logic              clk;
  logic              reset_n;
  logic              flush;
  logic [NUM_RS-1:0] rs_empty;
  logic              br_empty;
  logic              lsq_empty;
  logic              rob_full;
  logic              deq_valid;
  logic [DW-1:0]     deq_data;
  logic [NUM_RS-1:0] rs_load;
  logic              br_load;
  logic              lsq_load;
  logic              rob_load;
  logic              rf_alloc;
  logic [3:0]        count;
  logic              afull;

  int passed = 0;
  int total  = 0;

  dispatch_queue_if #(.DW(DW)) enq_if ();

  dispatch_queue #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .NUM_RS(NUM_RS)
  ) dut (
    .clk_i             (clk),
    .reset_n_i         (reset_n),
    .flush_i           (flush),
    .enq_if            (enq_if.slave),
    .rs_empty_i        (rs_empty),
    .br_empty_i        (br_empty),
    .lsq_empty_i       (lsq_empty),
    .rob_full_i        (rob_full),
    .deq_valid_o       (deq_valid),
    .deq_data_o        (deq_data),
    .rs_load_o         (rs_load),
    .br_load_o         (br_load),
    .lsq_load_o        (lsq_load),
    .rob_load_o        (rob_load),
    .regfile_allocate_o(rf_alloc),
    .count_o           (count),
    .afull_o           (afull)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance past the next rising edge, then settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [1:0] cls, input logic [DW-1:0] d);
    enq_if.enq_valid_i = v;
    enq_if.enq_class_i = cls;
    enq_if.enq_data_i  = d;
  endtask

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    rs_empty  = '0;
    br_empty  = 1'b0;
    lsq_empty = 1'b0;
    rob_full  = 1'b1;
    offer(1'b0, 2'd0, '0);
    #12;

    // Reset state
    chk("rst_count", DW'(count), DW'(0));
    chk("rst_deq_valid", DW'(deq_valid), DW'(0));
    chk("rst_enq_ready", DW'(enq_if.enq_ready_o), DW'(1));
    chk("rst_afull", DW'(afull), DW'(0));
    chk("rst_rob_load", DW'(rob_load), DW'(0));
    chk("rst_deq_data", deq_data, DW'(0));

    reset_n = 1'b1;
    step();

    // Fill without dispatch (ROB full)
    offer(1'b1, 2'd0, DW'(1));
    #1;
    chk("no_bypass_valid", DW'(deq_valid), DW'(0));
    for (int i = 0; i < 8; i++) begin
      offer(1'b1, 2'd0, DW'(i + 1));
      step();
      chk($sformatf("fill_count_%0d", i), DW'(count), DW'(i + 1));
      chk($sformatf("fill_afull_%0d", i), DW'(afull), DW'((i + 1) >= 6));
    end
    chk("full_ready", DW'(enq_if.enq_ready_o), DW'(0));
    chk("full_rob_load", DW'(rob_load), DW'(0));
    offer(1'b1, 2'd0, DW'(99));
    step();
    chk("ninth_count", DW'(count), DW'(8));
    chk("ninth_head", deq_data, DW'(1));

    // ALU routing to lowest free station
    offer(1'b0, 2'd0, '0);
    rob_full = 1'b0;
    rs_empty = 4'b1010;
    #1;
    chk("alu_rs_load", DW'(rs_load), DW'(4'b0010));
    chk("alu_rob_load", DW'(rob_load), DW'(1));
    chk("alu_rf_alloc", DW'(rf_alloc), DW'(1));
    chk("alu_br_load", DW'(br_load), DW'(0));
    step();
    chk("alu_count", DW'(count), DW'(7));
    chk("alu_next_head", deq_data, DW'(2));
    rs_empty = 4'b0001;
    #1;
    chk("alu_rs_load0", DW'(rs_load), DW'(4'b0001));
    step();
    rs_empty = 4'b1000;
    #1;
    chk("alu_rs_load3", DW'(rs_load), DW'(4'b1000));
    step();
    chk("pre_flush_count", DW'(count), DW'(5));

    // Flush with a word on offer
    rs_empty = 4'b1111;
    flush    = 1'b1;
    offer(1'b1, 2'd0, DW'(77));
    #1;
    chk("flush_ready", DW'(enq_if.enq_ready_o), DW'(0));
    chk("flush_rob_load", DW'(rob_load), DW'(0));
    chk("flush_rs_load", DW'(rs_load), DW'(0));
    step();
    flush = 1'b0;
    offer(1'b0, 2'd0, '0);
    #1;
    chk("flush_count", DW'(count), DW'(0));
    chk("flush_deq_valid", DW'(deq_valid), DW'(0));
    chk("flush_deq_data", deq_data, DW'(0));
    step();
    chk("flush_dropped", DW'(count), DW'(0));

    // Enqueue STORE, BRANCH, LOAD behind a full ROB
    rob_full = 1'b1;
    offer(1'b1, 2'd3, DW'(16'hA000));
    step();
    chk("lat1_valid", DW'(deq_valid), DW'(1));
    chk("lat1_data", deq_data, DW'(16'hA000));
    offer(1'b1, 2'd1, DW'(16'hB000));
    step();
    offer(1'b1, 2'd2, DW'(16'hC000));
    step();
    offer(1'b0, 2'd0, '0);
    lsq_empty = 1'b1;
    #1;
    chk("robfull_lsq_load", DW'(lsq_load), DW'(0));
    chk("robfull_rob_load", DW'(rob_load), DW'(0));
    step();
    chk("robfull_count", DW'(count), DW'(3));
    chk("robfull_head", deq_data, DW'(16'hA000));
    rob_full = 1'b0;
    #1;
    chk("store_lsq_load", DW'(lsq_load), DW'(1));
    chk("store_rob_load", DW'(rob_load), DW'(1));
    chk("store_rf_alloc", DW'(rf_alloc), DW'(0));
    step();
    br_empty = 1'b0;
    #1;
    chk("br_busy_load", DW'(br_load), DW'(0));
    chk("br_busy_lsq", DW'(lsq_load), DW'(0));
    step();
    chk("br_busy_head", deq_data, DW'(16'hB000));
    br_empty = 1'b1;
    #1;
    chk("branch_br_load", DW'(br_load), DW'(1));
    chk("branch_rf_alloc", DW'(rf_alloc), DW'(0));
    step();
    chk("load_head", deq_data, DW'(16'hC000));
    chk("load_lsq_load", DW'(lsq_load), DW'(1));
    chk("load_rf_alloc", DW'(rf_alloc), DW'(1));
    step();
    chk("drain_count", DW'(count), DW'(0));

    // Wrap-around stream: 3 resident, then 20 enqueue+dispatch cycles
    rob_full = 1'b1;
    rs_empty = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      offer(1'b1, 2'd0, DW'(100 + k));
      step();
    end
    rob_full = 1'b0;
    for (int k = 0; k < 20; k++) begin
      offer(1'b1, 2'd0, DW'(103 + k));
      #1;
      chk($sformatf("stream_data_%0d", k), deq_data, DW'(100 + k));
      chk($sformatf("stream_count_%0d", k), DW'(count), DW'(3));
      chk($sformatf("stream_rs_%0d", k), DW'(rs_load), DW'(4'b0001));
      step();
    end
    offer(1'b0, 2'd0, '0);
    rob_full = 1'b1;
    #1;
    chk("stream_end_count", DW'(count), DW'(3));
    chk("stream_end_head", deq_data, DW'(120));

    // Asynchronous reset mid-cycle with entries resident
    rob_full = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_count", DW'(count), DW'(0));
    chk("arst_deq_valid", DW'(deq_valid), DW'(0));
    chk("arst_rob_load", DW'(rob_load), DW'(0));
    chk("arst_rs_load", DW'(rs_load), DW'(0));
    chk("arst_enq_ready", DW'(enq_if.enq_ready_o), DW'(1));
    step();
    reset_n = 1'b1;
    step();
    chk("post_rst_count", DW'(count), DW'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
